// File: rtl/knn_topk_collector_if.sv
// Handshake and data bundle between the L2 distance kernel, the top-K
// collector and the result writer.
// Optional macro: KNN_LEAF_TAG_EN adds the out_leaf result field.
interface knn_topk_collector_if #(
   parameter int DIST_WIDTH = 25,
   parameter int IDX_WIDTH  = 9,
   parameter int LEAF_SIZE  = 8,
   parameter int K          = 4,
   parameter int LEAF_ADDRW = 6
);
   logic                            in_valid;
   logic                            in_ready;
   logic                            query_first;
   logic                            query_last;
   logic [LEAF_ADDRW-1:0]           leaf_idx;
   logic [LEAF_SIZE*DIST_WIDTH-1:0] cand_dist;
   logic [LEAF_SIZE*IDX_WIDTH-1:0]  cand_idx;
   logic                            out_valid;
   logic                            out_ready;
   logic [K*DIST_WIDTH-1:0]         out_dist;
   logic [K*IDX_WIDTH-1:0]          out_idx;
`ifdef KNN_LEAF_TAG_EN
   logic [K*LEAF_ADDRW-1:0]         out_leaf;
`endif

   // Kernel / result-writer side (drives beats, accepts results).
   modport master (
      output in_valid, query_first, query_last, leaf_idx, cand_dist, cand_idx, out_ready,
      input  in_ready, out_valid, out_dist, out_idx
`ifdef KNN_LEAF_TAG_EN
      , input out_leaf
`endif
   );

   // Collector side.
   modport slave (
      input  in_valid, query_first, query_last, leaf_idx, cand_dist, cand_idx, out_ready,
      output in_ready, out_valid, out_dist, out_idx
`ifdef KNN_LEAF_TAG_EN
      , output out_leaf
`endif
   );
endinterface

// File: rtl/knn_topk_collector.sv
// Top-K nearest-neighbour collector: merges eight-wide distance beats into
// a sorted list of the K smallest distances, one candidate per cycle, and
// presents the list to the result writer on the last beat of a query.
// Optional macro: KNN_LEAF_TAG_EN stores and reports the leaf of each entry.
module knn_topk_collector #(
   parameter int DIST_WIDTH = 25,
   parameter int IDX_WIDTH  = 9,
   parameter int LEAF_SIZE  = 8,
   parameter int K          = 4,
   parameter int LEAF_ADDRW = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   knn_topk_collector_if.slave    bus
);
   localparam int CNTW = (LEAF_SIZE > 1) ? $clog2(LEAF_SIZE) : 1;
   localparam logic [CNTW-1:0]       CNT_LAST = CNTW'(LEAF_SIZE - 1);
   localparam logic [DIST_WIDTH-1:0] DIST_MAX = {DIST_WIDTH{1'b1}};

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_INSERT = 2'd1, ST_OUTPUT = 2'd2} state_t;

   state_t                          state_r, state_n_s;
   logic                            in_ready_r, out_valid_r;
   logic [CNTW-1:0]                 cnt_r;
   logic [LEAF_SIZE*DIST_WIDTH-1:0] beat_dist_r;
   logic [LEAF_SIZE*IDX_WIDTH-1:0]  beat_idx_r;
   logic                            beat_last_r;
   logic [DIST_WIDTH-1:0]           list_dist_r [K];
   logic [IDX_WIDTH-1:0]            list_idx_r  [K];
   logic [DIST_WIDTH-1:0]           ins_dist_s  [K];
   logic [IDX_WIDTH-1:0]            ins_idx_s   [K];
   logic [DIST_WIDTH-1:0]           cur_dist_s;
   logic [IDX_WIDTH-1:0]            cur_idx_s;
   logic [K-1:0]                    lt_s;
   logic                            accept_s, insert_s, clear_s;
`ifdef KNN_LEAF_TAG_EN
   logic [LEAF_ADDRW-1:0]           beat_leaf_r;
   logic [LEAF_ADDRW-1:0]           list_leaf_r [K];
   logic [LEAF_ADDRW-1:0]           ins_leaf_s  [K];
`endif

   // Handshake decode: beat acceptance, insertion phase and list clear.
   always_comb begin
      accept_s = in_ready_r & bus.in_valid;
      insert_s = (state_r == ST_INSERT);
      clear_s  = (accept_s & bus.query_first) |
                 ((state_r == ST_OUTPUT) & bus.out_ready);
   end

   // Next-state logic for the accept / insert / output sequence.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_n_s = ST_INSERT;
            else          state_n_s = ST_IDLE;
         end
         ST_INSERT: begin
            if (cnt_r == CNT_LAST) state_n_s = beat_last_r ? ST_OUTPUT : ST_IDLE;
            else                   state_n_s = ST_INSERT;
         end
         ST_OUTPUT: begin
            if (bus.out_ready) state_n_s = ST_IDLE;
            else               state_n_s = ST_OUTPUT;
         end
         default: state_n_s = ST_IDLE;
      endcase
   end

   // Select the current candidate and compute the shifted list with it inserted.
   // The list is ascending, so lt_s is a thermometer: the first set bit is
   // the insertion rank, ranks above it take their upper neighbour.
   always_comb begin
      cur_dist_s = beat_dist_r[int'(cnt_r)*DIST_WIDTH +: DIST_WIDTH];
      cur_idx_s  = beat_idx_r[int'(cnt_r)*IDX_WIDTH +: IDX_WIDTH];
      for (int r = 0; r < K; r++) begin
         lt_s[r]       = (cur_dist_s < list_dist_r[r]);
         ins_dist_s[r] = list_dist_r[r];
         ins_idx_s[r]  = list_idx_r[r];
`ifdef KNN_LEAF_TAG_EN
         ins_leaf_s[r] = list_leaf_r[r];
`endif
      end
      if (lt_s[0]) begin
         ins_dist_s[0] = cur_dist_s;
         ins_idx_s[0]  = cur_idx_s;
`ifdef KNN_LEAF_TAG_EN
         ins_leaf_s[0] = beat_leaf_r;
`endif
      end else begin
         ins_dist_s[0] = list_dist_r[0];
      end
      for (int r = 1; r < K; r++) begin
         if (lt_s[r] && lt_s[r-1]) begin
            ins_dist_s[r] = list_dist_r[r-1];
            ins_idx_s[r]  = list_idx_r[r-1];
`ifdef KNN_LEAF_TAG_EN
            ins_leaf_s[r] = list_leaf_r[r-1];
`endif
         end else if (lt_s[r]) begin
            ins_dist_s[r] = cur_dist_s;
            ins_idx_s[r]  = cur_idx_s;
`ifdef KNN_LEAF_TAG_EN
            ins_leaf_s[r] = beat_leaf_r;
`endif
         end else begin
            ins_dist_s[r] = list_dist_r[r];
         end
      end
   end

   // State register, registered handshake flags and candidate counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         cnt_r       <= '0;
      end else begin
         state_r     <= state_n_s;
         in_ready_r  <= (state_n_s == ST_IDLE);
         out_valid_r <= (state_n_s == ST_OUTPUT);
         if (accept_s)      cnt_r <= '0;
         else if (insert_s) cnt_r <= cnt_r + CNTW'(1);
      end
   end

   // Latch the accepted beat for the insertion phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_dist_r <= '0;
         beat_idx_r  <= '0;
         beat_last_r <= 1'b0;
`ifdef KNN_LEAF_TAG_EN
         beat_leaf_r <= '0;
`endif
      end else if (accept_s) begin
         beat_dist_r <= bus.cand_dist;
         beat_idx_r  <= bus.cand_idx;
         beat_last_r <= bus.query_last;
`ifdef KNN_LEAF_TAG_EN
         beat_leaf_r <= bus.leaf_idx;
`endif
      end
   end

   // Sorted list: clear on reset/new query/result handshake, else insert.
   always_ff @(posedge clk) begin
      for (int r = 0; r < K; r++) begin
         if (rst || clear_s) begin
            list_dist_r[r] <= DIST_MAX;
            list_idx_r[r]  <= '0;
`ifdef KNN_LEAF_TAG_EN
            list_leaf_r[r] <= '0;
`endif
         end else if (insert_s) begin
            list_dist_r[r] <= ins_dist_s[r];
            list_idx_r[r]  <= ins_idx_s[r];
`ifdef KNN_LEAF_TAG_EN
            list_leaf_r[r] <= ins_leaf_s[r];
`endif
         end
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;

   for (genvar r = 0; r < K; r++) begin : g_out
      assign bus.out_dist[r*DIST_WIDTH +: DIST_WIDTH] = list_dist_r[r];
      assign bus.out_idx[r*IDX_WIDTH +: IDX_WIDTH]    = list_idx_r[r];
`ifdef KNN_LEAF_TAG_EN
      assign bus.out_leaf[r*LEAF_ADDRW +: LEAF_ADDRW] = list_leaf_r[r];
`endif
   end
endmodule

// File: doc/knn_topk_collector.md
Name: knn_topk_collector

Overview:
- Consumes the eight-wide distance beats produced by the L2 distance kernel.
- Keeps a running sorted list of the K nearest candidates for the current query, merging every beat between query_first and query_last.
- On the last beat of a query, emits the sorted K distances and patch indices to the result writer.
- Inserts one candidate per cycle, and applies backpressure to the kernel-side pipeline through in_ready.

Parameters:
DIST_WIDTH, 25, width of one L2 distance
IDX_WIDTH, 9, patch index width
LEAF_SIZE, 8, candidates per input beat
K, 4, nearest neighbours kept per query
LEAF_ADDRW, 6, leaf index width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  beat valid; equals kernel dist_valid
in_ready  out  1  collector can accept a beat
query_first  in  1  beat is first of a query
query_last  in  1  beat is last of a query
leaf_idx  in  LEAF_ADDRW  leaf that produced the beat
cand_dist  in  LEAF_SIZE*DIST_WIDTH  packed distances, slot 0 in LSBs
cand_idx  in  LEAF_SIZE*IDX_WIDTH  packed patch indices, slot 0 in LSBs
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_dist  out  K*DIST_WIDTH  sorted distances, rank 0 (smallest) in LSBs
out_idx  out  K*IDX_WIDTH  indices matching out_dist
out_leaf  out  K*LEAF_ADDRW  present only with KNN_LEAF_TAG_EN

Behaviour:
- Reset (rst=1 at a clk edge, any state):
  - State goes to IDLE; in_ready=1; out_valid=0.
  - out_dist and all list distances are all-ones; out_idx, list indices and out_leaf are 0.
  - Any partial query is discarded.
- FSM IDLE:
  - in_ready=1.
  - A beat is accepted when in_valid and in_ready are both high at an edge.
  - On acceptance, the collector latches cand_dist, cand_idx, leaf_idx and query_last, clears the candidate counter c, and moves to INSERT.
  - If query_first is set on the accepted beat, the list is cleared to all-ones/0 at that same edge.
- FSM INSERT:
  - in_ready=0.
  - Each cycle inserts candidate c into the sorted list:
    - Find the first rank r with cand_dist[c] < list_dist[r] (strict).
    - Shift ranks r..K-2 down by one, discard rank K-1, write the candidate at r.
    - If no such r exists, the candidate is dropped.
  - Ties keep the incumbent, so earlier beats and lower slots win equal distances.
  - After c=LEAF_SIZE-1, go to OUTPUT if the latched query_last is set, else to IDLE.
- Latency:
  - Beat accepted at edge E; insertions happen at edges E+1..E+LEAF_SIZE.
  - in_ready is high again in the cycle after E+LEAF_SIZE for non-last beats.
  - out_valid is high in the cycle after E+LEAF_SIZE for last beats.
- FSM OUTPUT:
  - out_valid=1, in_ready=0.
  - out_dist, out_idx and out_leaf hold the list and stay stable until out_valid && out_ready at an edge.
  - On that handshake: out_valid drops, the list is cleared, and the state goes to IDLE.
- The outputs are the list registers. They are updated in INSERT, but are only meaningful while out_valid=1.
- A beat with query_first=0 that arrives after a completed query merges into the already-cleared list, which is equivalent to an implicit first.
- A beat with query_first=1 and query_last=1 does a clear, LEAF_SIZE insertions, then output.
- query_first in the middle of a query discards the partial list (clear wins).
- Distances are unsigned compares only; no arithmetic widening.
- When fewer than K real candidates are merged, unused ranks report all-ones distance and index 0.

Optional Feature:
- Macro KNN_LEAF_TAG_EN.
- Defined:
  - Each list entry also stores the LEAF_ADDRW leaf_idx of its beat, shifted together with its entry.
  - The out_leaf port exists and is cleared to 0 on reset and on list clear.
- Undefined:
  - No leaf storage and no out_leaf port.
  - Ranking and timing are identical either way.

Test Plan:
- Single beat, first=last=1, dists {80,10,70,20,60,30,50,40} (slot0..7), idx 100..107 -> out_valid 9 cycles after accept; out_dist {10,20,30,40}, out_idx {101,103,105,107}.
- Two beats, first then last. Beat A dists all 50, idx 0..7; beat B dists {49,50,51,...}, idx 8..15 -> out_dist {49,50,50,50}, out_idx {8,0,1,2}. This checks the tie rule.
- in_valid held high during INSERT and OUTPUT -> no beat accepted while in_ready=0. Holding out_ready=0 for 5 cycles -> out_valid and out data stay stable; the next beat is accepted only after the handshake.
- Distance all-ones in every slot -> all candidates dropped; out_dist is all-ones, out_idx is 0.
- rst asserted at the 4th INSERT cycle -> next cycle in_ready=1, out_valid=0. A fresh first/last beat then produces only its own results.
- With KNN_LEAF_TAG_EN: beats with leaf_idx 2 and 5 -> out_leaf matches the leaf that supplied each ranked entry.
